// File: rtl/disp_data_latch_pkg.sv
// Shared types, default parameters and width helper for the display data latch.
package disp_pkg;

  // Handshake/hold state of the latch.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam int DIV_DEF         = 50000;
  localparam int DIGITS_DEF      = 4;
  localparam int HOLD_FRAMES_DEF = 4;

  localparam int DATA_W = 4;
  localparam int IDX_W  = 2;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/disp_data_latch_if.sv
// Producer-side handshake plus the display-facing outputs of the latch.
interface disp_data_latch_if;
  import disp_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] disp_data;
  logic [IDX_W-1:0]  digit_idx;
  logic              scan_tick;
  logic              frame_done;

  // Producer / observer side.
  modport master (
    output in_data, in_valid,
    input  in_ready, disp_data, digit_idx, scan_tick, frame_done
  );

  // The latch itself.
  modport slave (
    input  in_data, in_valid,
    output in_ready, disp_data, digit_idx, scan_tick, frame_done
  );
endinterface

// File: rtl/disp_data_latch_scan_prescaler.sv
// Free-running digit scan: prescaler, registered slot-end strobe and digit index.
module scan_prescaler
  import disp_pkg::*;
#(
  parameter int DIV    = DIV_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic             clk,
  input  logic             res,
  output logic             scan_tick,
  output logic [IDX_W-1:0] digit_idx,
  output logic             frame_done
);

  localparam int               PW     = cnt_width(DIV);
  localparam logic [PW-1:0]    P_LAST = PW'(DIV - 1);
  localparam logic [IDX_W-1:0] D_LAST = IDX_W'(DIGITS - 1);

  logic [PW-1:0]    r_presc;
  logic [PW-1:0]    w_presc_next;
  logic             r_tick;
  logic [IDX_W-1:0] r_idx;

  // Next prescaler value, wrapping at DIV-1.
  always_comb begin
    w_presc_next = (r_presc == P_LAST) ? '0 : r_presc + PW'(1);
  end

  // The strobe is registered from the next count so it is high exactly while the count sits at DIV-1.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_presc_next;
      r_tick  <= (w_presc_next == P_LAST);
      if (r_tick) begin
        r_idx <= (r_idx == D_LAST) ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  assign scan_tick  = r_tick;
  assign digit_idx  = r_idx;
  assign frame_done = r_tick & (r_idx == D_LAST);

endmodule

// File: rtl/disp_data_latch.sv
// Holds an accepted nibble stable for a minimum number of full scan frames.
module disp_data_latch
  import disp_pkg::*;
#(
  parameter int DIV         = DIV_DEF,
  parameter int DIGITS      = DIGITS_DEF,
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
  input  logic               clk,
  input  logic               res,
  disp_data_latch_if.slave   bus
);

  localparam int            CW     = cnt_width(HOLD_FRAMES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(HOLD_FRAMES);

  state_t            r_state, w_state_next;
  logic [CW-1:0]     r_cnt, w_cnt_next;
  logic [DATA_W-1:0] r_data, w_data_next;
  logic              r_ready, w_ready_next;
  logic              w_accept;
  logic              w_scan_tick;
  logic              w_frame_done;
  logic [IDX_W-1:0]  w_digit_idx;

  scan_prescaler #(
    .DIV    (DIV),
    .DIGITS (DIGITS)
  ) u_scan (
    .clk        (clk),
    .res        (res),
    .scan_tick  (w_scan_tick),
    .digit_idx  (w_digit_idx),
    .frame_done (w_frame_done)
  );

  assign w_accept = bus.in_valid & r_ready;

  // Next-state logic: accept wins over a coincident frame_done because READY never counts frames.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_data_next  = r_data;
    w_ready_next = r_ready;
    case (r_state)
      EMPTY, READY: begin
        w_ready_next = 1'b1;
        if (w_accept) begin
          w_data_next  = bus.in_data;
          w_cnt_next   = '0;
          w_state_next = HOLD;
          w_ready_next = 1'b0;
        end
      end
      HOLD: begin
        w_ready_next = 1'b0;
        if (w_frame_done) begin
          w_cnt_next = r_cnt + CW'(1);
          if (r_cnt + CW'(1) == C_LAST) begin
            w_state_next = READY;
            w_ready_next = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = EMPTY;
        w_ready_next = 1'b0;
      end
    endcase
  end

  // State, frame counter, held data and registered ready.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= EMPTY;
      r_cnt   <= '0;
      r_data  <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_data  <= w_data_next;
      r_ready <= w_ready_next;
    end
  end

  assign bus.in_ready   = r_ready;
  assign bus.disp_data  = r_data;
  assign bus.digit_idx  = w_digit_idx;
  assign bus.scan_tick  = w_scan_tick;
  assign bus.frame_done = w_frame_done;

endmodule

// File: tb/tb_disp_data_latch.sv
// Directed bench for disp_data_latch with a cycle-count scan model and a data scoreboard.
module tb_disp_data_latch;

  logic clk;
  logic res_a;
  logic res_b;
  int   errors;
  int   checks;
  int   ka;
  int   kb;
  int   kc;
  int   m;
  bit   got;
  logic [3:0] exp_q[$];
  logic [3:0] drv;

  disp_data_latch_if bus_a();
  disp_data_latch_if bus_b();

  disp_data_latch #(.DIV(4), .DIGITS(4), .HOLD_FRAMES(2)) dut_a (
    .clk (clk),
    .res (res_a),
    .bus (bus_a.slave)
  );

  disp_data_latch #(.DIV(1), .DIGITS(4), .HOLD_FRAMES(1)) dut_b (
    .clk (clk),
    .res (res_b),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release, one counter per DUT.
  always @(posedge clk or negedge res_a) begin
    if (!res_a) ka <= 0;
    else        ka <= ka + 1;
  end
  always @(posedge clk or negedge res_b) begin
    if (!res_b) kb <= 0;
    else        kb <= kb + 1;
  end

  // Scan model: k edges after reset release.
  function automatic bit m_tick(input int k, input int div);
    return (k >= 1) && ((k % div) == (div - 1));
  endfunction

  function automatic int m_idx(input int k, input int div, input int digits);
    int n = 0;
    for (int j = 0; j < k; j++) if (m_tick(j, div)) n++;
    return n % digits;
  endfunction

  function automatic bit m_fd(input int k, input int div, input int digits);
    return m_tick(k, div) && (m_idx(k, div, digits) == digits - 1);
  endfunction

  // Edge count at which ready returns after a capture at edge kc.
  function automatic int m_ready_edge(input int kcap, input int div, input int digits, input int hf);
    int c = 0;
    for (int j = kcap; j < kcap + 4096; j++) begin
      if (m_fd(j, div, digits)) begin
        c++;
        if (c == hf) return j + 1;
      end
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [3:0] obs);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=%0d expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {28'd0, obs}, {28'd0, e});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    res_a = 1'b0;
    res_b = 1'b0;
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = 4'h0;
    bus_b.in_valid = 1'b0;
    bus_b.in_data  = 4'h0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_data",  bus_a.disp_data,  0);
    chk("rst_ready", bus_a.in_ready,   0);
    chk("rst_idx",   bus_a.digit_idx,  0);
    chk("rst_tick",  bus_a.scan_tick,  0);
    chk("rst_fd",    bus_a.frame_done, 0);

    // Release: ready only after the first edge
    res_a = 1'b1;
    #1;
    chk("rel_ready0", bus_a.in_ready, 0);
    @(negedge clk);
    chk("rel_ready1", bus_a.in_ready, 1);

    // Free-running scan against the model
    for (int i = 0; i < 20; i++) begin
      chk("scan_tick", bus_a.scan_tick,  m_tick(ka, 4));
      chk("scan_idx",  bus_a.digit_idx,  m_idx(ka, 4, 4));
      chk("scan_fd",   bus_a.frame_done, m_fd(ka, 4, 4));
      @(negedge clk);
    end

    // Capture 4'hA in EMPTY
    chk("capA_ready", bus_a.in_ready, 1);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 4'hA;
    exp_q.push_back(4'hA);
    @(negedge clk);
    kc = ka;
    m  = m_ready_edge(kc, 4, 4, 2);
    sb_check("capA_data", bus_a.disp_data);
    chk("capA_busy", bus_a.in_ready, 0);

    // HOLD ignores toggling data with valid held high
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      bus_a.in_data = n[0] ? 4'h5 : 4'h3;
      @(negedge clk);
      if (bus_a.in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      chk("holdA_data", bus_a.disp_data, 4'hA);
    end
    chk("holdA_done", got, 1);
    chk("holdA_len", ka - kc, m - kc);
    // Valid still high: the pending value transfers on the first ready cycle
    drv = bus_a.in_data;
    exp_q.push_back(drv);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    kc = ka;
    m  = m_ready_edge(kc, 4, 4, 2);
    sb_check("stream_data", bus_a.disp_data);
    chk("stream_busy", bus_a.in_ready, 0);
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus_a.in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("hold2_done", got, 1);
    chk("hold2_len", ka - kc, m - kc);

    // Accept in READY exactly on a frame_done cycle
    for (int n = 0; n < 20; n++) begin
      if (m_fd(ka, 4, 4)) break;
      @(negedge clk);
    end
    chk("fd_coinc", bus_a.frame_done, 1);
    chk("fd_ready", bus_a.in_ready, 1);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 4'h7;
    exp_q.push_back(4'h7);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    kc = ka;
    m  = m_ready_edge(kc, 4, 4, 2);
    sb_check("cap7_data", bus_a.disp_data);
    chk("cap7_busy", bus_a.in_ready, 0);
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus_a.in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      chk("hold7_data", bus_a.disp_data, 4'h7);
    end
    chk("hold7_done", got, 1);
    chk("hold7_len", ka - kc, m - kc);

    // Reset pulse between edges during HOLD
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 4'h9;
    exp_q.push_back(4'h9);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    sb_check("cap9_data", bus_a.disp_data);
    repeat (5) @(negedge clk);
    #2;
    res_a = 1'b0;
    #1;
    chk("arst_data",  bus_a.disp_data, 0);
    chk("arst_idx",   bus_a.digit_idx, 0);
    chk("arst_ready", bus_a.in_ready,  0);
    chk("arst_tick",  bus_a.scan_tick, 0);
    res_a = 1'b1;
    @(negedge clk);
    chk("restart_ready", bus_a.in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      chk("restart_tick", bus_a.scan_tick, m_tick(ka, 4));
      chk("restart_idx",  bus_a.digit_idx, m_idx(ka, 4, 4));
      @(negedge clk);
    end
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 4'hC;
    exp_q.push_back(4'hC);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    kc = ka;
    m  = m_ready_edge(kc, 4, 4, 2);
    sb_check("capC_data", bus_a.disp_data);
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus_a.in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("holdC_done", got, 1);
    chk("holdC_len", ka - kc, m - kc);

    // DIV=1, HOLD_FRAMES=1 instance
    chk("b_rst_data", bus_b.disp_data, 0);
    chk("b_rst_tick", bus_b.scan_tick, 0);
    res_b = 1'b1;
    #1;
    chk("b_rel_ready0", bus_b.in_ready, 0);
    @(negedge clk);
    chk("b_rel_ready1", bus_b.in_ready, 1);
    for (int i = 0; i < 9; i++) begin
      chk("b_tick", bus_b.scan_tick,  m_tick(kb, 1));
      chk("b_idx",  bus_b.digit_idx,  m_idx(kb, 1, 4));
      chk("b_fd",   bus_b.frame_done, m_fd(kb, 1, 4));
      @(negedge clk);
    end
    for (int t = 0; t < 3; t++) begin
      drv = 4'h6 + 4'(t);
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = drv;
      exp_q.push_back(drv);
      @(negedge clk);
      bus_b.in_valid = 1'b0;
      kc = kb;
      m  = m_ready_edge(kc, 1, 4, 1);
      sb_check("b_cap_data", bus_b.disp_data);
      got = 1'b0;
      for (int n = 0; n < 10; n++) begin
        if (bus_b.in_ready === 1'b1) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("b_hold_done", got, 1);
      chk("b_hold_len", kb - kc, m - kc);
      // Shift the capture phase for the next round
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
